// File: rtl/mips_write_monitor.sv
// mips_write_monitor: checks the data-memory write port of the single-cycle
// MIPS top level against a programmable table of expected writes.
// It reports pass, fail or timeout and keeps match and write counters.
// Optional build macro WMON_UNORDERED_EN makes matching order-free. A
// per-entry matched bitmap then replaces the in-order match pointer.
module mips_write_monitor #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 8,
  parameter int IGNORE_ADDR    = 80,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [WIDTH-1:0]           dataadr,
  input  logic [WIDTH-1:0]           writedata,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [WIDTH-1:0]           cfg_addr,
  input  logic [WIDTH-1:0]           cfg_data,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
  input  logic                       start,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH+1)-1:0] match_count,
  output logic [15:0]                write_count,
  output logic [WIDTH-1:0]           fail_addr,
  output logic [WIDTH-1:0]           fail_data
);
  localparam int IW = $clog2(DEPTH);
  localparam int MW = $clog2(DEPTH+1);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES+1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    len_q, len_d;
  logic [MW-1:0]    match_q, match_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] faddr_q, faddr_d;
  logic [WIDTH-1:0] fdata_q, fdata_d;

  // Expected-write table; deliberately left out of reset so it survives one
  logic [WIDTH-1:0] tab_addr_q [DEPTH];
  logic [WIDTH-1:0] tab_data_q [DEPTH];

  logic checked;
  logic hit;

  // Table programming, accepted only while idle and for in-range indices
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE && int'(cfg_idx) < DEPTH) begin
      tab_addr_q[cfg_idx] <= cfg_addr;
      tab_data_q[cfg_idx] <= cfg_data;
    end
  end

  // Writes to the ignore address never participate in checking
  assign checked = memwrite && (dataadr != WIDTH'(IGNORE_ADDR));

`ifdef WMON_UNORDERED_EN
  logic [DEPTH-1:0] matched_q, matched_d;
  logic [IW-1:0]    hit_idx;

  // Lowest-index unmatched valid entry equal to the write (scan top-down so the lowest wins)
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (i < int'(len_q) && !matched_q[i] &&
          tab_addr_q[i] == dataadr && tab_data_q[i] == writedata) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  // In-order: the write must equal the entry at the match pointer
  always_comb begin
    ptr = IW'(match_q);
    hit = (tab_addr_q[ptr] == dataadr) && (tab_data_q[ptr] == writedata);
  end
`endif

  // State and run-time registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      match_q   <= '0;
      wcnt_q    <= '0;
      cyc_q     <= '0;
      faddr_q   <= '0;
      fdata_q   <= '0;
`ifdef WMON_UNORDERED_EN
      matched_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      match_q   <= match_d;
      wcnt_q    <= wcnt_d;
      cyc_q     <= cyc_d;
      faddr_q   <= faddr_d;
      fdata_q   <= fdata_d;
`ifdef WMON_UNORDERED_EN
      matched_q <= matched_d;
`endif
    end
  end

  // Next state: the write outcome is applied after the timeout check so it takes priority
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    match_d   = match_q;
    wcnt_d    = wcnt_q;
    cyc_d     = cyc_q;
    faddr_d   = faddr_q;
    fdata_d   = fdata_q;
`ifdef WMON_UNORDERED_EN
    matched_d = matched_q;
`endif
    case (state_q)
      S_RUN: begin
        cyc_d = cyc_q + CW'(1);
        if (TIMEOUT_CYCLES != 0 && cyc_d == CW'(TIMEOUT_CYCLES))
          state_d = S_TIMEOUT;
        if (checked) begin
          if (wcnt_q != 16'hFFFF)
            wcnt_d = wcnt_q + 16'd1;
          if (hit) begin
            match_d = match_q + MW'(1);
`ifdef WMON_UNORDERED_EN
            matched_d[hit_idx] = 1'b1;
`endif
            if (match_d == len_q)
              state_d = S_PASS;
          end else begin
            state_d = S_FAIL;
            faddr_d = dataadr;
            fdata_d = writedata;
          end
        end
        // An empty table passes on the first run cycle regardless of traffic
        if (len_q == '0)
          state_d = S_PASS;
      end
      default: begin
        // IDLE and the terminal states all (re)start identically
        if (start) begin
          state_d   = S_RUN;
          len_d     = (int'(cfg_len) > DEPTH) ? MW'(DEPTH) : cfg_len;
          match_d   = '0;
          wcnt_d    = '0;
          cyc_d     = '0;
          faddr_d   = '0;
          fdata_d   = '0;
`ifdef WMON_UNORDERED_EN
          matched_d = '0;
`endif
        end
      end
    endcase
  end

  // Status decode straight from registered state and counters
  always_comb begin
    pass        = (state_q == S_PASS);
    fail        = (state_q == S_FAIL);
    timeout     = (state_q == S_TIMEOUT);
    done        = pass | fail | timeout;
    match_count = match_q;
    write_count = wcnt_q;
    fail_addr   = faddr_q;
    fail_data   = fdata_q;
  end

endmodule

// File: doc/mips_write_monitor.md
Name: mips_write_monitor

Overview:
- Synthesizable, parametrised write-checker for the single-cycle MIPS top level.
- Watches the processor's data-memory write port: memwrite, dataadr and writedata.
- Compares writes against a programmable expected-write table.
- Reports pass, fail or timeout through registered status outputs and keeps diagnostic counters, so benches and FPGA builds share one checker.

Parameters:
- WIDTH, 32, width of address and data buses.
- DEPTH, 8, number of expected-write table entries.
- IGNORE_ADDR, 80, address whose writes are never checked or counted as failures.
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before TIMEOUT; 0 disables timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- memwrite  in  1  processor write strobe.
- dataadr  in  WIDTH  processor write address.
- writedata  in  WIDTH  processor write data.
- cfg_we  in  1  table write strobe; honoured only in IDLE.
- cfg_idx  in  $clog2(DEPTH)  table entry index.
- cfg_addr  in  WIDTH  expected address.
- cfg_data  in  WIDTH  expected data.
- cfg_len  in  $clog2(DEPTH+1)  number of valid entries; sampled on start.
- start  in  1  single-cycle pulse beginning a check run.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  run completed; all entries matched.
- fail  out  1  unexpected write seen.
- timeout  out  1  cycle budget exhausted.
- match_count  out  $clog2(DEPTH+1)  entries matched so far.
- write_count  out  16  checked writes in this run, saturating at 16'hFFFF; ignored writes excluded.
- fail_addr  out  WIDTH  address of the first offending write.
- fail_data  out  WIDTH  data of the first offending write.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE; all outputs 0; fail_addr and fail_data 0.
  - match pointer/bitmap, cycle counter and latched length 0.
  - Table contents are not reset.
- States:
  - IDLE: cfg_we writes entry cfg_idx. start latches cfg_len, clears the counters, fail_addr and fail_data, then moves to RUN next cycle.
  - RUN: a write is checked in every cycle with memwrite=1.
    - A write is checked against the entry at the match pointer; index equals match_count.
    - dataadr==IGNORE_ADDR: no effect.
    - Match: match_count increments and write_count increments. If the new match_count equals the latched length, go to PASS.
    - Mismatch: go to FAIL; capture dataadr and writedata into fail_addr and fail_data; write_count increments.
    - The cycle counter increments every RUN cycle. On reaching TIMEOUT_CYCLES (when nonzero), go to TIMEOUT.
  - PASS, FAIL, TIMEOUT: terminal; inputs ignored except start, which restarts exactly as from IDLE using the existing table.
- Output latency: status outputs are registered and assert the cycle after the deciding write.
- Boundary conditions:
  - A latched length of 0 goes to PASS on the first RUN cycle, with no write required.
  - start together with memwrite in the same cycle: the write is not checked.
  - cfg_we outside IDLE is ignored; a cfg_idx at or above DEPTH is ignored.
  - A cfg_len larger than DEPTH is clamped to DEPTH.
  - Match/mismatch on the same cycle the cycle counter reaches its limit: the write outcome (PASS or FAIL) wins over TIMEOUT.
  - IGNORE_ADDR writes may repeat without limit.
  - Reset mid-RUN aborts immediately; no status is asserted.
- Exactly one of pass, fail and timeout is high when done=1.

Optional Feature:
- Macro: WMON_UNORDERED_EN.
- Defined:
  - Matching is order-free. A per-entry matched bitmap replaces the pointer.
  - A write matches the lowest-index unmatched valid entry with equal address and data; that entry is marked and match_count increments.
  - A write matching no unmatched entry (including an exact repeat) is FAIL.
  - PASS when all valid entries are marked.
- Undefined: strict in-order matching as above; the bitmap logic is absent.

Test Plan:
- Table {(84,7)}, cfg_len=1, start; writes (80,x), (80,y), (84,7) -> pass=1 and done=1 one cycle after the (84,7) write; match_count=1; write_count=1.
- Same table; write (88,7) -> fail=1, fail_addr=88, fail_data=7; a later write (84,7) leaves the state unchanged.
- TIMEOUT_CYCLES=20, table {(84,7)}, no writes -> timeout=1 after 20 RUN cycles; pass=0; fail=0.
- Table {(60,1),(64,2)}, cfg_len=2; writes (64,2) then (60,1) -> FAIL with fail_addr=64 when the macro is undefined; pass=1 with match_count=2 when WMON_UNORDERED_EN is defined.
- cfg_len=0, start -> pass=1 on the second cycle after start.
- Assert reset mid-RUN after one match -> all outputs 0 immediately; then start with the existing table and write (84,7) -> pass=1.
